mem_stage_lsu: RTL and testbench

- Parametrised successor to the pipeline memory stage. Sits between fetch/decode/execute and writeback.
- Registers execute results through to writeback. Performs RV loads and stores through a request/acknowledge data-memory port with variable wait states.
- Covers byte, half, word and (DWIDTH=64) double accesses, with sign/zero extension and misalignment detection.
- Provides wait-timeout abort, flush-during-transaction handling and upstream stall generation.

---
 rtl/mem_stage_lsu_pkg.sv | 30 +++
 rtl/mem_stage_lsu_align.sv | 66 ++++++
 rtl/mem_stage_lsu.sv | 184 ++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the memory stage load/store unit.
// Holds the RV funct3 access encodings, the stage FSM state type and the
// helpers that derive strobe width and byte-offset width from DWIDTH.
package mem_stage_lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;   // LB / SB
   localparam logic [2:0] F3_H  = 3'b001;   // LH / SH
   localparam logic [2:0] F3_W  = 3'b010;   // LW / SW
   localparam logic [2:0] F3_D  = 3'b011;   // LD / SD (DWIDTH=64 only)
   localparam logic [2:0] F3_BU = 3'b100;   // LBU
   localparam logic [2:0] F3_HU = 3'b101;   // LHU
   localparam logic [2:0] F3_WU = 3'b110;   // LWU (DWIDTH=64 only)

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,   // ready to accept
      S_WAIT = 2'd1,   // request outstanding
      S_DROP = 2'd2    // request outstanding, result to be discarded
   } state_t;

   // STRB_W = DWIDTH/8
   function automatic int unsigned strb_w(input int unsigned dwidth);
      return dwidth / 8;
   endfunction

   // OFF_W = log2(STRB_W)
   function automatic int unsigned off_w(input int unsigned dwidth);
      return $clog2(dwidth / 8);
   endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational lane steering for the load/store unit.
// Ports:
//   st_funct3, is_store, st_off, sdata : incoming access (size/sign, direction,
//                                        byte offset, store data)
//   ld_funct3, ld_off, rdata           : captured load access and memory read data
//   wstrb, wdata                       : byte strobes and lane-replicated store data
//   ldata                              : selected, sign/zero-extended load data
//   misalign                           : illegal funct3 or misaligned address
module lsu_align
   import mem_stage_lsu_pkg::*;
#(
   parameter int unsigned DWIDTH = 32,
   parameter int unsigned STRB_W = DWIDTH / 8,
   parameter int unsigned OFF_W  = $clog2(DWIDTH / 8)
)(
   input  logic [2:0]        st_funct3,
   input  logic              is_store,
   input  logic [OFF_W-1:0]  st_off,
   input  logic [DWIDTH-1:0] sdata,
   input  logic [2:0]        ld_funct3,
   input  logic [OFF_W-1:0]  ld_off,
   input  logic [DWIDTH-1:0] rdata,
   output logic [STRB_W-1:0] wstrb,
   output logic [DWIDTH-1:0] wdata,
   output logic [DWIDTH-1:0] ldata,
   output logic              misalign
);

   logic              legal;
   logic [1:0]        sz;
   logic [DWIDTH-1:0] sh;

   always_comb begin
      sz = st_funct3[1:0];
      if (is_store)
         legal = (st_funct3 inside {F3_B, F3_H, F3_W}) ||
                 ((DWIDTH == 64) && (st_funct3 == F3_D));
      else
         legal = (st_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) ||
                 ((DWIDTH == 64) && (st_funct3 inside {F3_D, F3_WU}));
      // An access of 2**sz bytes needs the low sz offset bits clear.
      misalign = !legal || ((32'(st_off) & ((32'd1 << sz) - 32'd1)) != 32'd0);
      // (2**(2**sz) - 1) gives 1, 3, 0xF, 0xFF for byte..double.
      wstrb = STRB_W'(((32'd1 << (32'd1 << sz)) - 32'd1) << st_off);
      case (sz)
         2'd0:    wdata = {STRB_W{sdata[7:0]}};
         2'd1:    wdata = {(DWIDTH / 16){sdata[15:0]}};
         2'd2:    wdata = {(DWIDTH / 32){sdata[31:0]}};
         default: wdata = sdata;
      endcase
   end

   always_comb begin
      sh = rdata >> {ld_off, 3'b000};
      case (ld_funct3)
         F3_B:    ldata = DWIDTH'($signed(sh[7:0]));
         F3_H:    ldata = DWIDTH'($signed(sh[15:0]));
         F3_W:    ldata = DWIDTH'($signed(sh[31:0]));
         F3_BU:   ldata = DWIDTH'(sh[7:0]);
         F3_HU:   ldata = DWIDTH'(sh[15:0]);
         F3_WU:   ldata = DWIDTH'(sh[31:0]);
         default: ldata = sh;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// Pipeline memory stage with load/store unit.
// Registers execute results through to writeback and performs loads/stores
// over a req/ack data-memory port with variable wait states, ack timeout,
// flush handling and upstream stall generation.
// Ports:
//   ml_clk, ml_rst            : clock, asynchronous active-low reset
//   ml_i_*                    : instruction from execute, downstream stall, flush
//   ml_m_*                    : data-memory request/acknowledge port
//   ml_o_rd_*, ml_o_ce        : result to writeback
//   ml_o_stall                : upstream stall
//   ml_o_misalign/ml_o_timeout: one-cycle error flags alongside ml_o_ce
module mem_stage_lsu
   import mem_stage_lsu_pkg::*;
#(
   parameter int unsigned DWIDTH      = 32,
   parameter int unsigned AWIDTH      = 5,
   parameter int unsigned FUNCT_WIDTH = 3,
   parameter int unsigned MAWIDTH     = 32,
   parameter int unsigned TIMEOUT     = 64
)(
   input  logic                   ml_clk,
   input  logic                   ml_rst,
   input  logic                   ml_i_ce,
   input  logic                   ml_i_load,
   input  logic                   ml_i_store,
   input  logic [FUNCT_WIDTH-1:0] ml_i_funct3,
   input  logic [DWIDTH-1:0]      ml_i_alu_value,
   input  logic [DWIDTH-1:0]      ml_i_rs2_data,
   input  logic [AWIDTH-1:0]      ml_i_rd_addr,
   input  logic [DWIDTH-1:0]      ml_i_rd_data,
   input  logic                   ml_i_rd_we,
   input  logic                   ml_i_stall,
   input  logic                   ml_i_flush,
   output logic                   ml_m_req,
   output logic                   ml_m_we,
   output logic [MAWIDTH-1:0]     ml_m_addr,
   output logic [DWIDTH-1:0]      ml_m_wdata,
   output logic [DWIDTH/8-1:0]    ml_m_wstrb,
   input  logic                   ml_m_ack,
   input  logic [DWIDTH-1:0]      ml_m_rdata,
   output logic                   ml_o_ce,
   output logic [AWIDTH-1:0]      ml_o_rd_addr,
   output logic [DWIDTH-1:0]      ml_o_rd_data,
   output logic                   ml_o_rd_we,
   output logic                   ml_o_stall,
   output logic                   ml_o_misalign,
   output logic                   ml_o_timeout
);

   localparam int unsigned STRB_W = strb_w(DWIDTH);
   localparam int unsigned OFF_W  = off_w(DWIDTH);

   state_t              state_q, state_d;
   logic [7:0]          cnt;
   logic [2:0]          ld_f3;
   logic [OFF_W-1:0]    ld_off;
   logic                is_load_q;
   logic                rd_we_q;

   logic [MAWIDTH-1:0]  eff;
   logic                mem_op, accept, ack, expire, misalign;
   logic [STRB_W-1:0]   wstrb;
   logic [DWIDTH-1:0]   wdata, ldata;

   assign eff        = MAWIDTH'(ml_i_alu_value);
   assign mem_op     = ml_i_load | ml_i_store;
   assign accept     = (state_q == S_IDLE) && ml_i_ce && !ml_i_stall && !ml_i_flush;
   assign ack        = ml_m_req & ml_m_ack;
   assign expire     = (cnt == 8'(TIMEOUT - 1));
   assign ml_o_stall = ml_i_stall | (state_q != S_IDLE);

   lsu_align #(
      .DWIDTH (DWIDTH),
      .STRB_W (STRB_W),
      .OFF_W  (OFF_W)
   ) u_align (
      .st_funct3 (ml_i_funct3[2:0]),
      .is_store  (ml_i_store),
      .st_off    (eff[OFF_W-1:0]),
      .sdata     (ml_i_rs2_data),
      .ld_funct3 (ld_f3),
      .ld_off    (ld_off),
      .rdata     (ml_m_rdata),
      .wstrb     (wstrb),
      .wdata     (wdata),
      .ldata     (ldata),
      .misalign  (misalign)
   );

   always_ff @(posedge ml_clk or negedge ml_rst) begin
      if (!ml_rst) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (accept && mem_op && !misalign) state_d = S_WAIT;
         S_WAIT:  if (ack || expire)                 state_d = S_IDLE;
                  else if (ml_i_flush)               state_d = S_DROP;
         S_DROP:  if (ack || expire)                 state_d = S_IDLE;
         default:                                    state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge ml_clk or negedge ml_rst) begin
      if (!ml_rst) begin
         cnt           <= '0;
         ld_f3         <= '0;
         ld_off        <= '0;
         is_load_q     <= 1'b0;
         rd_we_q       <= 1'b0;
         ml_m_req      <= 1'b0;
         ml_m_we       <= 1'b0;
         ml_m_addr     <= '0;
         ml_m_wdata    <= '0;
         ml_m_wstrb    <= '0;
         ml_o_ce       <= 1'b0;
         ml_o_rd_addr  <= '0;
         ml_o_rd_data  <= '0;
         ml_o_rd_we    <= 1'b0;
         ml_o_misalign <= 1'b0;
         ml_o_timeout  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // A stalled IDLE cycle freezes the outputs unless it is flushed.
               if (!ml_i_stall || ml_i_flush) begin
                  ml_o_ce       <= 1'b0;
                  ml_o_misalign <= 1'b0;
                  ml_o_timeout  <= 1'b0;
                  if (accept) begin
                     ml_o_rd_addr <= ml_i_rd_addr;
                     ml_o_rd_data <= ml_i_rd_data;
                     if (!mem_op) begin
                        ml_o_ce    <= 1'b1;
                        ml_o_rd_we <= ml_i_rd_we;
                     end else if (misalign) begin
                        ml_o_ce       <= 1'b1;
                        ml_o_rd_we    <= 1'b0;
                        ml_o_misalign <= 1'b1;
                     end else begin
                        ml_o_rd_we <= 1'b0;
                        ml_m_req   <= 1'b1;
                        ml_m_we    <= ml_i_store;
                        ml_m_addr  <= eff & ~MAWIDTH'(STRB_W - 1);
                        ml_m_wdata <= wdata;
                        ml_m_wstrb <= wstrb;
                        cnt        <= '0;
                        ld_f3      <= ml_i_funct3[2:0];
                        ld_off     <= eff[OFF_W-1:0];
                        is_load_q  <= !ml_i_store;
                        rd_we_q    <= ml_i_rd_we;
                     end
                  end
               end
            end
            default: begin
               ml_o_ce       <= 1'b0;
               ml_o_misalign <= 1'b0;
               ml_o_timeout  <= 1'b0;
               if (ack || expire) begin
                  ml_m_req <= 1'b0;
                  ml_m_we  <= 1'b0;
                  // A flush in DROP, or arriving with the ack/timeout, discards the result.
                  if ((state_q == S_WAIT) && !ml_i_flush) begin
                     ml_o_ce <= 1'b1;
                     if (ack) begin
                        ml_o_rd_we <= is_load_q & rd_we_q;
                        if (is_load_q) ml_o_rd_data <= ldata;
                     end else begin
                        ml_o_rd_we   <= 1'b0;
                        ml_o_timeout <= 1'b1;
                     end
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu (DWIDTH=32, TIMEOUT=4).
module tb_mem_stage_lsu;

   logic        ml_clk, ml_rst;
   logic        ml_i_ce, ml_i_load, ml_i_store;
   logic [2:0]  ml_i_funct3;
   logic [31:0] ml_i_alu_value, ml_i_rs2_data, ml_i_rd_data;
   logic [4:0]  ml_i_rd_addr;
   logic        ml_i_rd_we, ml_i_stall, ml_i_flush;
   logic        ml_m_req, ml_m_we;
   logic [31:0] ml_m_addr, ml_m_wdata, ml_m_rdata;
   logic [3:0]  ml_m_wstrb;
   logic        ml_m_ack;
   logic        ml_o_ce;
   logic [4:0]  ml_o_rd_addr;
   logic [31:0] ml_o_rd_data;
   logic        ml_o_rd_we, ml_o_stall, ml_o_misalign, ml_o_timeout;

   int checks = 0;
   int errors = 0;

   mem_stage_lsu #(
      .DWIDTH(32), .AWIDTH(5), .FUNCT_WIDTH(3), .MAWIDTH(32), .TIMEOUT(4)
   ) dut (
      .ml_clk(ml_clk), .ml_rst(ml_rst),
      .ml_i_ce(ml_i_ce), .ml_i_load(ml_i_load), .ml_i_store(ml_i_store),
      .ml_i_funct3(ml_i_funct3), .ml_i_alu_value(ml_i_alu_value),
      .ml_i_rs2_data(ml_i_rs2_data), .ml_i_rd_addr(ml_i_rd_addr),
      .ml_i_rd_data(ml_i_rd_data), .ml_i_rd_we(ml_i_rd_we),
      .ml_i_stall(ml_i_stall), .ml_i_flush(ml_i_flush),
      .ml_m_req(ml_m_req), .ml_m_we(ml_m_we), .ml_m_addr(ml_m_addr),
      .ml_m_wdata(ml_m_wdata), .ml_m_wstrb(ml_m_wstrb),
      .ml_m_ack(ml_m_ack), .ml_m_rdata(ml_m_rdata),
      .ml_o_ce(ml_o_ce), .ml_o_rd_addr(ml_o_rd_addr), .ml_o_rd_data(ml_o_rd_data),
      .ml_o_rd_we(ml_o_rd_we), .ml_o_stall(ml_o_stall),
      .ml_o_misalign(ml_o_misalign), .ml_o_timeout(ml_o_timeout)
   );

   initial ml_clk = 1'b0;
   always #5 ml_clk = ~ml_clk;

   task automatic tick();
      @(posedge ml_clk);
      #1;
   endtask

   task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] rs2,
                        input logic [4:0] rda, input logic [31:0] rdd, input logic we);
      ml_i_ce = 1'b1; ml_i_load = ld; ml_i_store = st; ml_i_funct3 = f3;
      ml_i_alu_value = alu; ml_i_rs2_data = rs2; ml_i_rd_addr = rda;
      ml_i_rd_data = rdd; ml_i_rd_we = we;
   endtask

   task automatic idle_in();
      ml_i_ce = 1'b0; ml_i_load = 1'b0; ml_i_store = 1'b0;
   endtask

   task automatic test_reset();
      ml_rst = 1'b0; idle_in(); ml_i_funct3 = '0; ml_i_alu_value = '0;
      ml_i_rs2_data = '0; ml_i_rd_addr = '0; ml_i_rd_data = '0; ml_i_rd_we = 1'b0;
      ml_i_stall = 1'b0; ml_i_flush = 1'b0; ml_m_ack = 1'b0; ml_m_rdata = '0;
      #12;
      checks++; if (ml_m_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", ml_m_req); end
      checks++; if (ml_o_ce !== 1'b0) begin errors++; $display("FAIL reset_ce: got %0b want 0", ml_o_ce); end
      checks++; if (ml_o_rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", ml_o_rd_data); end
      checks++; if (ml_o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", ml_o_stall); end
      ml_rst = 1'b1;
      tick();
   endtask

   task automatic test_alu();
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd5, 32'h1234, 1'b1);
      tick(); idle_in();
      checks++; if (ml_o_ce !== 1'b1) begin errors++; $display("FAIL alu_ce: got %0b want 1", ml_o_ce); end
      checks++; if (ml_o_rd_addr !== 5'd5) begin errors++; $display("FAIL alu_rd_addr: got %0d want 5", ml_o_rd_addr); end
      checks++; if (ml_o_rd_data !== 32'h1234) begin errors++; $display("FAIL alu_rd_data: got %h want 00001234", ml_o_rd_data); end
      checks++; if (ml_o_rd_we !== 1'b1) begin errors++; $display("FAIL alu_rd_we: got %0b want 1", ml_o_rd_we); end
      checks++; if (ml_m_req !== 1'b0) begin errors++; $display("FAIL alu_req: got %0b want 0", ml_m_req); end
      tick();
      checks++; if (ml_o_ce !== 1'b0 || ml_m_req !== 1'b0) begin errors++; $display("FAIL alu_idle: got ce=%0b req=%0b want 0,0", ml_o_ce, ml_m_req); end
   endtask

   task automatic test_stall_flush_idle();
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd6, 32'hBEEF, 1'b1);
      tick();
      checks++; if (ml_o_ce !== 1'b1) begin errors++; $display("FAIL stall_pre_ce: got %0b want 1", ml_o_ce); end
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd9, 32'h9999, 1'b1);
      ml_i_stall = 1'b1;
      tick();
      checks++; if (ml_o_ce !== 1'b1 || ml_o_rd_data !== 32'hBEEF) begin errors++; $display("FAIL stall_hold: got ce=%0b data=%h want 1,0000beef", ml_o_ce, ml_o_rd_data); end
      checks++; if (ml_o_stall !== 1'b1) begin errors++; $display("FAIL stall_pass: got %0b want 1", ml_o_stall); end
      ml_i_stall = 1'b0; ml_i_flush = 1'b1;
      tick(); ml_i_flush = 1'b0; idle_in();
      checks++; if (ml_o_ce !== 1'b0 || ml_o_rd_data !== 32'hBEEF) begin errors++; $display("FAIL flush_idle: got ce=%0b data=%h want 0,0000beef", ml_o_ce, ml_o_rd_data); end
   endtask

   task automatic test_load_byte();
      drive(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd7, 32'h0, 1'b1);
      tick(); idle_in();
      checks++; if (ml_m_req !== 1'b1 || ml_m_we !== 1'b0 || ml_m_addr !== 32'h100) begin errors++; $display("FAIL lb_req: got req=%0b we=%0b addr=%h want 1,0,00000100", ml_m_req, ml_m_we, ml_m_addr); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (ml_m_req !== 1'b1 || ml_o_stall !== 1'b1 || ml_o_ce !== 1'b0) begin errors++; $display("FAIL lb_wait%0d: got req=%0b stall=%0b ce=%0b want 1,1,0", i, ml_m_req, ml_o_stall, ml_o_ce); end
         tick();
      end
      ml_m_ack = 1'b1; ml_m_rdata = 32'h80FF_FF00;
      tick(); ml_m_ack = 1'b0;
      checks++; if (ml_m_req !== 1'b0 || ml_o_ce !== 1'b1) begin errors++; $display("FAIL lb_done: got req=%0b ce=%0b want 0,1", ml_m_req, ml_o_ce); end
      checks++; if (ml_o_rd_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data: got %h want ffffff80", ml_o_rd_data); end
      checks++; if (ml_o_rd_we !== 1'b1 || ml_o_rd_addr !== 5'd7) begin errors++; $display("FAIL lb_rd: got we=%0b addr=%0d want 1,7", ml_o_rd_we, ml_o_rd_addr); end
      checks++; if (ml_o_stall !== 1'b0) begin errors++; $display("FAIL lb_stall_end: got %0b want 0", ml_o_stall); end
      drive(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 5'd8, 32'h0, 1'b1);
      tick(); idle_in();
      ml_m_ack = 1'b1;
      tick(); ml_m_ack = 1'b0;
      checks++; if (ml_o_ce !== 1'b1 || ml_o_rd_data !== 32'h0000_0080) begin errors++; $display("FAIL lbu_data: got ce=%0b data=%h want 1,00000080", ml_o_ce, ml_o_rd_data); end
   endtask

   task automatic test_store_half();
      drive(1'b0, 1'b1, 3'b001, 32'h202, 32'hABCD, 5'd3, 32'h55, 1'b1);
      tick(); idle_in();
      checks++; if (ml_m_addr !== 32'h200) begin errors++; $display("FAIL sh_addr: got %h want 00000200", ml_m_addr); end
      checks++; if (ml_m_wstrb !== 4'b1100) begin errors++; $display("FAIL sh_wstrb: got %b want 1100", ml_m_wstrb); end
      checks++; if (ml_m_wdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_wdata: got %h want abcdabcd", ml_m_wdata); end
      checks++; if (ml_m_we !== 1'b1 || ml_m_req !== 1'b1) begin errors++; $display("FAIL sh_we: got we=%0b req=%0b want 1,1", ml_m_we, ml_m_req); end
      tick();
      ml_m_ack = 1'b1;
      tick(); ml_m_ack = 1'b0;
      checks++; if (ml_o_ce !== 1'b1 || ml_o_rd_we !== 1'b0 || ml_m_req !== 1'b0) begin errors++; $display("FAIL sh_done: got ce=%0b we=%0b req=%0b want 1,0,0", ml_o_ce, ml_o_rd_we, ml_m_req); end
   endtask

   task automatic test_misalign();
      drive(1'b1, 1'b0, 3'b010, 32'h006, 32'h0, 5'd4, 32'h0, 1'b1);
      tick(); idle_in();
      checks++; if (ml_o_ce !== 1'b1 || ml_o_misalign !== 1'b1 || ml_o_rd_we !== 1'b0) begin errors++; $display("FAIL lw_mis: got ce=%0b mis=%0b we=%0b want 1,1,0", ml_o_ce, ml_o_misalign, ml_o_rd_we); end
      checks++; if (ml_m_req !== 1'b0 || ml_o_stall !== 1'b0) begin errors++; $display("FAIL lw_mis_req: got req=%0b stall=%0b want 0,0", ml_m_req, ml_o_stall); end
      tick();
      checks++; if (ml_o_misalign !== 1'b0 || ml_o_ce !== 1'b0) begin errors++; $display("FAIL lw_mis_pulse: got mis=%0b ce=%0b want 0,0", ml_o_misalign, ml_o_ce); end
      drive(1'b1, 1'b0, 3'b011, 32'h000, 32'h0, 5'd4, 32'h0, 1'b1);
      tick(); idle_in();
      checks++; if (ml_o_misalign !== 1'b1 || ml_m_req !== 1'b0) begin errors++; $display("FAIL ld32_illegal: got mis=%0b req=%0b want 1,0", ml_o_misalign, ml_m_req); end
   endtask

   task automatic test_timeout();
      drive(1'b0, 1'b1, 3'b010, 32'h40, 32'h1122_3344, 5'd2, 32'h0, 1'b1);
      tick(); idle_in();
      checks++; if (ml_m_wstrb !== 4'hF || ml_m_wdata !== 32'h1122_3344 || ml_m_addr !== 32'h40) begin errors++; $display("FAIL sw_req: got strb=%h data=%h addr=%h want f,11223344,00000040", ml_m_wstrb, ml_m_wdata, ml_m_addr); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (ml_m_req !== 1'b1 || ml_o_ce !== 1'b0) begin errors++; $display("FAIL to_req%0d: got req=%0b ce=%0b want 1,0", i, ml_m_req, ml_o_ce); end
         tick();
      end
      checks++; if (ml_m_req !== 1'b0 || ml_o_ce !== 1'b1 || ml_o_timeout !== 1'b1 || ml_o_rd_we !== 1'b0) begin errors++; $display("FAIL to_abort: got req=%0b ce=%0b to=%0b we=%0b want 0,1,1,0", ml_m_req, ml_o_ce, ml_o_timeout, ml_o_rd_we); end
      ml_m_ack = 1'b1;
      tick(); ml_m_ack = 1'b0;
      checks++; if (ml_o_ce !== 1'b0 || ml_o_timeout !== 1'b0 || ml_m_req !== 1'b0 || ml_o_stall !== 1'b0) begin errors++; $display("FAIL to_late_ack: got ce=%0b to=%0b req=%0b stall=%0b want 0,0,0,0", ml_o_ce, ml_o_timeout, ml_m_req, ml_o_stall); end
   endtask

   task automatic test_flush_wait();
      drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd10, 32'h0, 1'b1);
      tick(); idle_in();
      checks++; if (ml_m_req !== 1'b1) begin errors++; $display("FAIL fl_req: got %0b want 1", ml_m_req); end
      ml_i_flush = 1'b1;
      tick(); ml_i_flush = 1'b0;
      checks++; if (ml_m_req !== 1'b1 || ml_o_ce !== 1'b0 || ml_o_stall !== 1'b1) begin errors++; $display("FAIL fl_drop: got req=%0b ce=%0b stall=%0b want 1,0,1", ml_m_req, ml_o_ce, ml_o_stall); end
      tick();
      ml_m_ack = 1'b1; ml_m_rdata = 32'h5555;
      tick(); ml_m_ack = 1'b0;
      checks++; if (ml_m_req !== 1'b0 || ml_o_ce !== 1'b0 || ml_o_timeout !== 1'b0 || ml_o_stall !== 1'b0) begin errors++; $display("FAIL fl_done: got req=%0b ce=%0b to=%0b stall=%0b want 0,0,0,0", ml_m_req, ml_o_ce, ml_o_timeout, ml_o_stall); end
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd11, 32'h4242, 1'b1);
      tick(); idle_in();
      checks++; if (ml_o_ce !== 1'b1 || ml_o_rd_data !== 32'h4242) begin errors++; $display("FAIL back_to_back: got ce=%0b data=%h want 1,00004242", ml_o_ce, ml_o_rd_data); end
   endtask

   task automatic test_reset_wait();
      drive(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 5'd12, 32'h0, 1'b1);
      tick(); idle_in();
      checks++; if (ml_m_req !== 1'b1) begin errors++; $display("FAIL rw_req: got %0b want 1", ml_m_req); end
      #2 ml_rst = 1'b0;
      #1;
      checks++; if (ml_m_req !== 1'b0 || ml_o_stall !== 1'b0) begin errors++; $display("FAIL rw_async: got req=%0b stall=%0b want 0,0", ml_m_req, ml_o_stall); end
      #2 ml_rst = 1'b1;
      tick();
      checks++; if (ml_m_req !== 1'b0 || ml_o_ce !== 1'b0) begin errors++; $display("FAIL rw_after: got req=%0b ce=%0b want 0,0", ml_m_req, ml_o_ce); end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_stall_flush_idle();
      test_load_byte();
      test_store_half();
      test_misalign();
      test_timeout();
      test_flush_wait();
      test_reset_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
